// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone register initiator.
package wb_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } wb_state_e;

  // Response status returned with every completed command.
  typedef logic [1:0] wb_status_t;

  localparam wb_status_t WB_RSP_OK      = 2'b00;
  localparam wb_status_t WB_RSP_ERR     = 2'b01;
  localparam wb_status_t WB_RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bounded-wait counter: clears on request, counts while enabled and
// saturates at TIMEOUT_CYCLES-1, where o_expired is raised.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expired = w_at_last;

  // Count idle bus cycles; hold at the last value instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/wb_reg_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus
// cycle out, one response back, with a bounded wait for ack/err.
module wb_reg_initiator
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 14,
  parameter int SEL_WIDTH      = (DATA_WIDTH + 7) / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  wb_state_e             r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  wb_status_t            r_rsp_status;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;

  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_expired;

  // Counter is parked at zero outside a transfer and only runs while the
  // slave has not answered.
  assign w_cnt_clr = (r_state == ST_IDLE);
  assign w_cnt_en  = (r_state == ST_BUS) && !wb_ack_i && !wb_err_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  assign cmd_ready_o  = r_cmd_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign rsp_status_o = r_rsp_status;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;

  // Transfer FSM: accept command, run one bus cycle, hold response until taken.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= WB_RSP_OK;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_we        <= cmd_we_i;
            r_adr       <= cmd_addr_i;
            r_dat       <= cmd_wdata_i;
            r_sel       <= cmd_sel_i;
            r_cyc       <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Error outranks ack, and any slave answer outranks the timeout.
          if (wb_err_i) begin
            r_cyc        <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= WB_RSP_ERR;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RSP;
          end else if (wb_ack_i) begin
            r_cyc        <= 1'b0;
            r_rsp_rdata  <= r_we ? '0 : wb_dat_i;
            r_rsp_status <= WB_RSP_OK;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RSP;
          end else if (w_expired) begin
            r_cyc        <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= WB_RSP_TIMEOUT;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg_initiator.sv
// Directed bench for wb_reg_initiator with a response scoreboard.
module tb_wb_reg_initiator;

  localparam int AW = 12;
  localparam int DW = 14;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry: {rdata, status}
  logic [DW+1:0] exp_q[$];

  always #5 clk = ~clk;

  wb_reg_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_status_o(rsp_status),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until the handshake edge; leaves the bench
  // one cycle after acceptance (first stb cycle).
  task automatic send_cmd(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    int waited;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_sel = s;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, consume it.
  task automatic take_rsp(input string tag);
    int waited;
    logic [DW+1:0] e;
    waited = 0;
    while (!rsp_valid && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, {18'd0, rsp_rdata}, {18'd0, e[DW+1:2]});
      check({tag, "_status"}, {30'd0, rsp_status}, {30'd0, e[1:0]});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int stb_cnt;

    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_status", {30'd0, rsp_status}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1) Write, zero-wait slave
    send_cmd(1'b1, 12'h010, 14'h2A5, 2'b11);
    exp_q.push_back({14'h0000, 2'b00});
    check("wr_stb", {31'd0, wb_stb}, 32'd1);
    check("wr_cyc", {31'd0, wb_cyc}, 32'd1);
    check("wr_we", {31'd0, wb_we}, 32'd1);
    check("wr_adr", {20'd0, wb_adr}, 32'h010);
    check("wr_dat", {18'd0, wb_dat_o}, 32'h2A5);
    check("wr_sel", {30'd0, wb_sel}, 32'h3);
    check("wr_ready_low", {31'd0, cmd_ready}, 32'd0);
    wb_dat_i = 14'h3FFF;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("wr_rsp_next", {31'd0, rsp_valid}, 32'd1);
    check("wr_stb_drop", {31'd0, wb_stb}, 32'd0);
    take_rsp("wr");

    // 2) Read with 3 wait states, ack on 4th stb cycle
    send_cmd(1'b0, 12'h004, 14'h0000, 2'b01);
    exp_q.push_back({14'h1F3C, 2'b00});
    for (int k = 0; k < 4; k++) begin
      check("rd_stb_hold", {31'd0, wb_stb}, 32'd1);
      check("rd_adr_hold", {20'd0, wb_adr}, 32'h004);
      check("rd_we_hold", {31'd0, wb_we}, 32'd0);
      check("rd_no_rsp", {31'd0, rsp_valid}, 32'd0);
      if (k == 3) begin
        wb_dat_i = 14'h1F3C;
        wb_ack = 1'b1;
      end
      tick();
    end
    wb_ack = 1'b0;
    wb_dat_i = '0;
    take_rsp("rd");

    // 3) ack and err together: err wins
    send_cmd(1'b0, 12'h020, 14'h0000, 2'b11);
    exp_q.push_back({14'h0000, 2'b01});
    wb_dat_i = 14'h1234;
    wb_ack = 1'b1;
    wb_err = 1'b1;
    tick();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    check("err_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    check("err_stb_drop", {31'd0, wb_stb}, 32'd0);
    take_rsp("err");

    // 4) Timeout: no answer, stb high exactly 16 cycles
    send_cmd(1'b0, 12'h0FF, 14'h0000, 2'b10);
    exp_q.push_back({14'h0000, 2'b10});
    stb_cnt = 0;
    while (wb_stb && stb_cnt < 40) begin
      stb_cnt++;
      tick();
    end
    check("to_stb_cycles", stb_cnt, 32'd16);
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    wb_ack = 1'b1;
    wb_dat_i = 14'h0555;
    tick();
    wb_ack = 1'b0;
    check("late_ack_status", {30'd0, rsp_status}, 32'h2);
    check("late_ack_rdata", {18'd0, rsp_rdata}, 32'd0);
    check("late_ack_cyc", {31'd0, wb_cyc}, 32'd0);
    take_rsp("to");
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);

    // 5) Backpressure with a pending command
    send_cmd(1'b0, 12'h030, 14'h0000, 2'b11);
    exp_q.push_back({14'h0155, 2'b00});
    wb_dat_i = 14'h0155;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    wb_dat_i = '0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h040; cmd_sel = 2'b01;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", {18'd0, rsp_rdata}, 32'h155);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_cyc", {31'd0, wb_cyc}, 32'd0);
      tick();
    end
    begin
      logic [DW+1:0] e;
      e = exp_q.pop_front();
      check("bp_sb_rdata", {18'd0, rsp_rdata}, {18'd0, e[DW+1:2]});
      check("bp_sb_status", {30'd0, rsp_status}, {30'd0, e[1:0]});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_post_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_post_stb", {31'd0, wb_stb}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back({14'h00AB, 2'b00});
    check("bp_pend_stb", {31'd0, wb_stb}, 32'd1);
    check("bp_pend_adr", {20'd0, wb_adr}, 32'h040);
    wb_dat_i = 14'h00AB;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    take_rsp("bp_pend");

    // 6) Async reset mid-BUS
    send_cmd(1'b1, 12'h050, 14'h0AAA, 2'b11);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cyc", {31'd0, wb_cyc}, 32'd0);
    check("ar_stb", {31'd0, wb_stb}, 32'd0);
    check("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send_cmd(1'b1, 12'h060, 14'h0123, 2'b10);
    exp_q.push_back({14'h0000, 2'b00});
    check("ar_next_adr", {20'd0, wb_adr}, 32'h060);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    take_rsp("ar_next");

    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
